// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU sequencer slice.
// Contents: instruction field bit positions, opcode constants, ALU function
// select (FS) encodings, FSM state encoding and an opcode legality helper.
package alu_seq_ctrl_pkg;

  localparam int INSTR_W = 16;

  // Instruction field bit positions
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS_MSB  = 8;
  localparam int RS_LSB  = 6;
  localparam int RT_MSB  = 5;
  localparam int RT_LSB  = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Opcodes; any op with bit 3 clear is an ALU op with FS = op[2:0]
  localparam logic [3:0] OP_LDI  = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // ALU function select encodings
  localparam logic [2:0] FS_ADD  = 3'b000;
  localparam logic [2:0] FS_SUB  = 3'b001;
  localparam logic [2:0] FS_AND  = 3'b010;
  localparam logic [2:0] FS_OR   = 3'b011;
  localparam logic [2:0] FS_XOR  = 3'b100;
  localparam logic [2:0] FS_NOT  = 3'b101;
  localparam logic [2:0] FS_AND2 = 3'b110;
  localparam logic [2:0] FS_OR2  = 3'b111;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DECODE    = 3'd1;
  localparam logic [2:0] ST_EXECUTE   = 3'd2;
  localparam logic [2:0] ST_WRITEBACK = 3'd3;
  localparam logic [2:0] ST_HALTED    = 3'd4;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op[3] == 1'b0) || (op == OP_LDI) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Instruction / result bus between an instruction source and alu_seq_ctrl.
// Handshake: an instruction transfers on a rising clock edge where both
// instr_valid and instr_ready are high. The source must hold instr_valid and
// instr stable until that edge; instr_ready never depends on instr_valid.
// Ports (master = source): instr_valid, instr out; instr_ready, result,
// result_valid, illegal, halted in. The slave modport is the mirror.
interface alu_seq_ctrl_if #(parameter int NBIT = 16);
  logic            instr_valid;
  logic            instr_ready;
  logic [15:0]     instr;
  logic [NBIT-1:0] result;
  logic            result_valid;
  logic            illegal;
  logic            halted;

  modport master (
    output instr_valid, instr,
    input  instr_ready, result, result_valid, illegal, halted
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, result, result_valid, illegal, halted
  );
endinterface

// File: rtl/alu.sv
// Combinational ALU.
// Ports: A, B operands; FS function select; F result (modulo 2^nBit).
module alu
  import alu_seq_ctrl_pkg::*;
#(
  parameter int nBit = 16
) (
  input  logic [nBit-1:0] A,
  input  logic [nBit-1:0] B,
  input  logic [2:0]      FS,
  output logic [nBit-1:0] F
);

  always_comb begin
    F = '0;
    case (FS)
      FS_ADD:          F = A + B;
      FS_SUB:          F = A - B;
      FS_AND, FS_AND2: F = A & B;
      FS_OR,  FS_OR2:  F = A | B;
      FS_XOR:          F = A ^ B;
      FS_NOT:          F = ~A;
      default:         F = '0;
    endcase
  end

endmodule

// File: rtl/regfile_2r1w.sv
// NREG x NBIT register file, two combinational read ports, one write port
// committed on the rising clock edge, asynchronous active-low clear.
// Ports: clk, rst_n; ra_addr/ra_data, rb_addr/rb_data read ports;
// we/wa/wd write port.
module regfile_2r1w #(
  parameter int NBIT = 16,
  parameter int NREG = 8,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra_addr,
  output logic [NBIT-1:0] ra_data,
  input  logic [AW-1:0]   rb_addr,
  output logic [NBIT-1:0] rb_data,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [NBIT-1:0] wd
);

  logic [NBIT-1:0] regs_q [NREG];
  logic [NBIT-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wa] = wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer for the ALU: accepts one instruction over the bus
// handshake, reads operands from the register file, runs the ALU, and writes
// the result back. Flow: IDLE -> DECODE -> EXECUTE -> WRITEBACK -> IDLE,
// with DECODE -> IDLE for illegal opcodes and DECODE -> HALTED for HALT.
// Ports: clk, rst_n (async, active low); bus (slave side of alu_seq_ctrl_if);
// state_dbg exposes the current FSM state.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
#(
  parameter int NBIT = 16,
  parameter int NREG = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_seq_ctrl_if.slave        bus,
  output logic [2:0]           state_dbg
);

  localparam int AW = $clog2(NREG);

  logic [2:0]         state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [NBIT-1:0]    a_q, a_d;
  logic [NBIT-1:0]    b_q, b_d;
  logic [NBIT-1:0]    res_q, res_d;
  logic [NBIT-1:0]    result_q, result_d;
  logic               halted_q, halted_d;
  logic               ready_q, ready_d;

  logic [3:0]         op;
  logic [NBIT-1:0]    rd_a, rd_b, alu_f, imm_ext;

  assign op      = ir_q[OP_MSB:OP_LSB];
  assign imm_ext = {{(NBIT-8){1'b0}}, ir_q[IMM_MSB:IMM_LSB]};

  regfile_2r1w #(.NBIT(NBIT), .NREG(NREG)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (ir_q[RS_MSB:RS_LSB]),
    .ra_data (rd_a),
    .rb_addr (ir_q[RT_MSB:RT_LSB]),
    .rb_data (rd_b),
    .we      (state_q == ST_WRITEBACK),
    .wa      (ir_q[RD_MSB:RD_LSB]),
    .wd      (res_q)
  );

  alu #(.nBit(NBIT)) u_alu (
    .A  (a_q),
    .B  (b_q),
    .FS (op[2:0]),
    .F  (alu_f)
  );

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    result_d = result_q;
    halted_d = halted_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid && ready_q) begin
          ir_d    = bus.instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d = rd_a;
        b_d = rd_b;
        if (op == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = ST_HALTED;
        end else if (op_is_legal(op)) begin
          state_d = ST_EXECUTE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXECUTE: begin
        // op[3] set here can only be LDI; HALT and illegal ops never reach EXECUTE
        res_d    = op[3] ? imm_ext : alu_f;
        // result is published on entry to WRITEBACK so it is valid with the pulse
        result_d = res_d;
        state_d  = ST_WRITEBACK;
      end
      ST_WRITEBACK: state_d = ST_IDLE;
      ST_HALTED:    state_d = ST_HALTED;
      default:      state_d = ST_IDLE;
    endcase
    // Registered so that ready is low throughout reset and rises one edge later
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      result_q <= '0;
      halted_q <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      result_q <= result_d;
      halted_q <= halted_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.instr_ready  = ready_q;
  assign bus.result       = result_q;
  assign bus.result_valid = (state_q == ST_WRITEBACK);
  assign bus.illegal      = (state_q == ST_DECODE) && !op_is_legal(op);
  assign bus.halted       = halted_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: hand-computed expected results for each
// instruction, cycle-exact checks of the handshake and output pulses.
module tb_alu_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [2:0] state_dbg;
  int         vectors;
  int         errs;

  alu_seq_ctrl_if #(.NBIT(16)) bus ();

  alu_seq_ctrl #(.NBIT(16), .NREG(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction encoders
  function automatic logic [15:0] alu_i(input logic [2:0] fs, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
    return {1'b0, fs, rd, rs, rt, 3'b000};
  endfunction

  function automatic logic [15:0] ldi_i(input logic [2:0] rd, input logic [7:0] imm);
    return {4'b1000, rd, 1'b0, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an instruction and complete the handshake edge
  task automatic drive(input logic [15:0] ins, input string tag);
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    for (int i = 0; i < 16 && bus.instr_ready !== 1'b1; i++) @(negedge clk);
    check($sformatf("%s_hs_ready", tag), {31'd0, bus.instr_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
  endtask

  // Full 4-cycle instruction with writeback of exp
  task automatic exec(input logic [15:0] ins, input logic [15:0] exp, input string tag);
    drive(ins, tag);
    @(negedge clk); // DECODE
    check($sformatf("%s_dec_ready", tag), {31'd0, bus.instr_ready}, 32'd0);
    check($sformatf("%s_dec_illegal", tag), {31'd0, bus.illegal}, 32'd0);
    @(negedge clk); // EXECUTE
    check($sformatf("%s_exe_ready", tag), {31'd0, bus.instr_ready}, 32'd0);
    check($sformatf("%s_exe_rv", tag), {31'd0, bus.result_valid}, 32'd0);
    @(negedge clk); // WRITEBACK
    check($sformatf("%s_wb_ready", tag), {31'd0, bus.instr_ready}, 32'd0);
    check($sformatf("%s_wb_rv", tag), {31'd0, bus.result_valid}, 32'd1);
    check($sformatf("%s_result", tag), {16'd0, bus.result}, {16'd0, exp});
    @(negedge clk); // back in IDLE
    check($sformatf("%s_idle_ready", tag), {31'd0, bus.instr_ready}, 32'd1);
    check($sformatf("%s_idle_rv", tag), {31'd0, bus.result_valid}, 32'd0);
    check($sformatf("%s_idle_result_hold", tag), {16'd0, bus.result}, {16'd0, exp});
  endtask

  initial begin
    vectors         = 0;
    errs            = 0;
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, bus.instr_ready}, 32'd0);
    check("rst_result", {16'd0, bus.result}, 32'd0);
    check("rst_rv", {31'd0, bus.result_valid}, 32'd0);
    check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    check("rst_halted", {31'd0, bus.halted}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", {31'd0, bus.instr_ready}, 32'd1);

    // Basic LDI / ADD
    exec(ldi_i(3'd1, 8'h05), 16'h0005, "ldi_r1");
    exec(ldi_i(3'd2, 8'h03), 16'h0003, "ldi_r2");
    exec(alu_i(3'b000, 3'd3, 3'd1, 3'd2), 16'h0008, "add_r3");

    // SUB, NOT, wrapping ADD
    exec(alu_i(3'b001, 3'd4, 3'd2, 3'd1), 16'hFFFE, "sub_r4");
    exec(alu_i(3'b101, 3'd5, 3'd0, 3'd0), 16'hFFFF, "not_r5");
    exec(alu_i(3'b000, 3'd6, 3'd5, 3'd1), 16'h0004, "add_wrap");

    // Build r2 = 0x0F3C: 0xF3 doubled four times is 0x0F30, then OR 0x0C
    exec(ldi_i(3'd2, 8'hF3), 16'h00F3, "ldi_f3");
    exec(alu_i(3'b000, 3'd2, 3'd2, 3'd2), 16'h01E6, "dbl1");
    exec(alu_i(3'b000, 3'd2, 3'd2, 3'd2), 16'h03CC, "dbl2");
    exec(alu_i(3'b000, 3'd2, 3'd2, 3'd2), 16'h0798, "dbl3");
    exec(alu_i(3'b000, 3'd2, 3'd2, 3'd2), 16'h0F30, "dbl4");
    exec(ldi_i(3'd7, 8'h0C), 16'h000C, "ldi_0c");
    exec(alu_i(3'b011, 3'd2, 3'd2, 3'd7), 16'h0F3C, "or_build");
    exec(ldi_i(3'd1, 8'hF0), 16'h00F0, "ldi_f0");

    // Logic ops with r1=0x00F0, r2=0x0F3C
    exec(alu_i(3'b010, 3'd3, 3'd1, 3'd2), 16'h0030, "and_010");
    exec(alu_i(3'b011, 3'd3, 3'd1, 3'd2), 16'h0FFC, "or_011");
    exec(alu_i(3'b100, 3'd3, 3'd1, 3'd2), 16'h0FCC, "xor_100");
    exec(alu_i(3'b110, 3'd3, 3'd1, 3'd2), 16'h0030, "and_110");
    exec(alu_i(3'b111, 3'd3, 3'd1, 3'd2), 16'h0FFC, "or_111");

    // rd == rs == rt, then confirm the write committed
    exec(ldi_i(3'd1, 8'h05), 16'h0005, "ldi_r1_5");
    exec(alu_i(3'b000, 3'd1, 3'd1, 3'd1), 16'h000A, "add_self");
    exec(alu_i(3'b000, 3'd2, 3'd1, 3'd0), 16'h000A, "add_r0");

    // Illegal opcode 1010
    drive(16'hA000, "illegal");
    @(negedge clk); // DECODE
    check("ill_pulse", {31'd0, bus.illegal}, 32'd1);
    check("ill_dec_ready", {31'd0, bus.instr_ready}, 32'd0);
    check("ill_dec_rv", {31'd0, bus.result_valid}, 32'd0);
    @(negedge clk);
    check("ill_pulse_end", {31'd0, bus.illegal}, 32'd0);
    check("ill_ready_back", {31'd0, bus.instr_ready}, 32'd1);
    check("ill_no_rv", {31'd0, bus.result_valid}, 32'd0);
    check("ill_result_hold", {16'd0, bus.result}, 32'h0000_000A);
    exec(alu_i(3'b000, 3'd4, 3'd2, 3'd0), 16'h000A, "ill_regs_kept");

    // Reset during EXECUTE aborts the instruction
    drive(alu_i(3'b000, 3'd3, 3'd1, 3'd2), "abort");
    @(negedge clk); // DECODE
    @(negedge clk); // EXECUTE
    check("abort_in_exe", {29'd0, state_dbg}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("abort_rv", {31'd0, bus.result_valid}, 32'd0);
    check("abort_illegal", {31'd0, bus.illegal}, 32'd0);
    check("abort_result", {16'd0, bus.result}, 32'd0);
    check("abort_ready", {31'd0, bus.instr_ready}, 32'd0);
    check("abort_state", {29'd0, state_dbg}, 32'd0);
    @(negedge clk);
    check("abort_rv_hold", {31'd0, bus.result_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exec(alu_i(3'b000, 3'd3, 3'd3, 3'd3), 16'h0000, "post_abort");

    // HALT
    drive(16'hF000, "halt");
    @(negedge clk); // DECODE
    check("halt_dec_ready", {31'd0, bus.instr_ready}, 32'd0);
    check("halt_dec_halted", {31'd0, bus.halted}, 32'd0);
    check("halt_dec_illegal", {31'd0, bus.illegal}, 32'd0);
    @(negedge clk);
    check("halt_set", {31'd0, bus.halted}, 32'd1);
    check("halt_ready", {31'd0, bus.instr_ready}, 32'd0);
    bus.instr_valid = 1'b1;
    bus.instr       = ldi_i(3'd1, 8'h55);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("halt_ign_ready_%0d", i), {31'd0, bus.instr_ready}, 32'd0);
      check($sformatf("halt_ign_rv_%0d", i), {31'd0, bus.result_valid}, 32'd0);
    end
    check("halt_sticky", {31'd0, bus.halted}, 32'd1);
    check("halt_state", {29'd0, state_dbg}, 32'd4);
    check("halt_result_hold", {16'd0, bus.result}, 32'd0);
    bus.instr_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
